// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, grant sources, byte counts.
package mem_arb_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DRAIN} arb_state_t;
  typedef enum logic [1:0] {G_NONE, G_IF, G_LD, G_ST} grant_src_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // A byte lane survives when its index lies below the transfer length.
  function automatic logic byte_kept(input int idx, input logic [2:0] len);
    return idx < int'(len);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: store > load > fetch, flush masks fetch/load,
// starvation flag promotes a waiting fetch to the top.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       st_req,
  input  logic       ld_req,
  input  logic       if_req,
  input  logic       flush,
  input  logic       starve,
  output grant_src_t grant
);

  logic if_ok;
  logic ld_ok;

  always_comb begin
    if_ok = if_req & ~flush;
    ld_ok = ld_req & ~flush;
    grant = G_NONE;
    if (starve && if_ok) grant = G_IF;
    else if (st_req)     grant = G_ST;
    else if (ld_ok)      grant = G_LD;
    else if (if_ok)      grant = G_IF;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter (fetch / load / store) in front of a single byte-serial memory controller.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long a pending fetch can be starved by data traffic.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_len,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_len,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_done,
  output logic              mc_read,
  output logic              mc_write,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_len,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_rdata
);

  arb_state_t        state;
  grant_src_t        grant;
  logic              starve;
  logic [DATA_W-1:0] ld_masked;

  mem_arb_pick u_pick (
    .st_req (st_req),
    .ld_req (ld_req),
    .if_req (if_req),
    .flush  (flush_in),
    .starve (starve),
    .grant  (grant)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign starve = (starve_cnt == 3'(STARVE_MAX));

  // Saturates at the limit so a flush-masked fetch cannot push the count past it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      starve_cnt <= '0;
    end else if (rdy_in) begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (state == IDLE) begin
        if (grant == G_IF)
          starve_cnt <= '0;
        else if ((grant == G_LD || grant == G_ST) && !starve)
          starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Load data is trimmed to the latched length before it reaches the requester.
  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_mask
    assign ld_masked[gi*8 +: 8] = byte_kept(gi, mc_len) ? mc_rdata[gi*8 +: 8] : 8'h00;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      if_done  <= 1'b0;
      ld_done  <= 1'b0;
      st_done  <= 1'b0;
      if_rdata <= '0;
      ld_rdata <= '0;
      mc_read  <= 1'b0;
      mc_write <= 1'b0;
      mc_addr  <= '0;
      mc_len   <= '0;
      mc_wdata <= '0;
    end else if (rdy_in) begin
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
      case (state)
        IDLE: begin
          case (grant)
            G_ST: begin
              state    <= STORE;
              mc_write <= 1'b1;
              mc_addr  <= st_addr;
              mc_len   <= st_len;
              mc_wdata <= st_wdata;
            end
            G_LD: begin
              state    <= LOAD;
              mc_read  <= 1'b1;
              mc_addr  <= ld_addr;
              mc_len   <= ld_len;
              mc_wdata <= '0;
            end
            G_IF: begin
              state    <= FETCH;
              mc_read  <= 1'b1;
              mc_addr  <= if_addr;
              mc_len   <= LEN_W;
              mc_wdata <= '0;
            end
            default: ;
          endcase
        end
        FETCH, LOAD: begin
          if (mc_done) begin
            state   <= IDLE;
            mc_read <= 1'b0;
            if (!flush_in) begin
              if (state == FETCH) begin
                if_done  <= 1'b1;
                if_rdata <= mc_rdata;
              end else begin
                ld_done  <= 1'b1;
                ld_rdata <= ld_masked;
              end
            end
          end else if (flush_in) begin
            state <= DRAIN;
          end
        end
        STORE: begin
          if (mc_done) begin
            state    <= IDLE;
            mc_write <= 1'b0;
            st_done  <= 1'b1;
          end
        end
        DRAIN: begin
          // The controller cannot be aborted; wait it out and drop the data.
          if (mc_done) begin
            state   <= IDLE;
            mc_read <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus directed scenarios and a
// randomized phase; the bench also plays the memory controller and the three requesters.
module tb_mem_arbiter;

  localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_len = 3'd4;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [2:0]  st_len = 3'd4;
  logic [31:0] st_wdata = '0;
  logic        st_done;
  logic        mc_read;
  logic        mc_write;
  logic [31:0] mc_addr;
  logic [2:0]  mc_len;
  logic [31:0] mc_wdata;
  logic        mc_done = 1'b0;
  logic [31:0] mc_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_wdata(st_wdata), .st_done(st_done),
    .mc_read(mc_read), .mc_write(mc_write), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: which source owns the controller (0 none, 1 fetch, 2 load, 3 store),
  // whether its result is to be discarded, and the starvation count.
  int          m_src = 0, m_cnt = 0, m_g = 0;
  bit          m_drop = 0;
  logic        e_read = 0, e_write = 0, e_if_done = 0, e_ld_done = 0, e_st_done = 0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_ld_rdata = '0;
  logic [2:0]  e_len = '0;

  // Stimulus / controller-emulation state.
  bit          rand_en = 0, rdy_rand = 0, keep_req = 0, fix_data_en = 0, ctl_active = 0;
  bit          prev_strobe = 0;
  int          ctl_delay = -1, ctl_wait = 0, nstep = 0, done_raise_step = 0;
  logic [31:0] fix_data = '0;
  logic [31:0] gq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] len_mask(input logic [2:0] len);
    if (len == 3'd1) return 32'h0000_00FF;
    if (len == 3'd2) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [2:0] rand_len();
    case ($urandom_range(0, 2))
      0: return 3'd1;
      1: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Advance the model over the clock edge that just passed (inputs are unchanged since then).
  task automatic model_update();
    if (!rst_in) begin
      m_src = 0; m_drop = 0; m_cnt = 0;
      e_read = 0; e_write = 0; e_addr = '0; e_len = '0; e_wdata = '0;
      e_if_done = 0; e_ld_done = 0; e_st_done = 0; e_if_rdata = '0; e_ld_rdata = '0;
    end else if (rdy_in) begin
      e_if_done = 0; e_ld_done = 0; e_st_done = 0;
      if (m_src == 0) begin
        m_g = 0;
        if (GUARD && m_cnt == SMAX && if_req && !flush_in) m_g = 1;
        else if (st_req)                                    m_g = 3;
        else if (ld_req && !flush_in)                       m_g = 2;
        else if (if_req && !flush_in)                       m_g = 1;
        if (!if_req || m_g == 1) m_cnt = 0;
        else if (m_g != 0 && m_cnt < SMAX) m_cnt++;
        m_src = m_g; m_drop = 0;
        case (m_g)
          1: begin e_read = 1; e_addr = if_addr; e_len = 3'd4; end
          2: begin e_read = 1; e_addr = ld_addr; e_len = ld_len; end
          3: begin e_write = 1; e_addr = st_addr; e_len = st_len; e_wdata = st_wdata; end
          default: ;
        endcase
      end else begin
        if (!if_req) m_cnt = 0;
        if (mc_done) begin
          if (!m_drop && !(flush_in && m_src != 3)) begin
            if (m_src == 1) begin e_if_done = 1; e_if_rdata = mc_rdata; end
            if (m_src == 2) begin e_ld_done = 1; e_ld_rdata = mc_rdata & len_mask(e_len); end
            if (m_src == 3) e_st_done = 1;
          end
          m_src = 0; e_read = 0; e_write = 0;
        end else if (flush_in && m_src != 3) begin
          m_drop = 1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("mc_read", 32'(mc_read), 32'(e_read));
    chk("mc_write", 32'(mc_write), 32'(e_write));
    chk("if_done", 32'(if_done), 32'(e_if_done));
    chk("ld_done", 32'(ld_done), 32'(e_ld_done));
    chk("st_done", 32'(st_done), 32'(e_st_done));
    if (e_read || e_write) begin
      chk("mc_addr", mc_addr, e_addr);
      chk("mc_len", 32'(mc_len), 32'(e_len));
    end
    if (e_write) chk("mc_wdata", mc_wdata, e_wdata);
    if (e_if_done) chk("if_rdata", if_rdata, e_if_rdata);
    if (e_ld_done) chk("ld_rdata", ld_rdata, e_ld_rdata);
  endtask

  // One cycle: check, play requesters and controller, then apply new stimulus.
  task automatic step();
    logic prev_rdy;
    @(negedge clk);
    nstep++;
    model_update();
    compare();
    if ((mc_read || mc_write) && !prev_strobe) gq.push_back(mc_addr);
    prev_strobe = mc_read || mc_write;
    if (!keep_req) begin
      if (if_req && (if_done || flush_in)) if_req = 0;
      if (ld_req && (ld_done || flush_in)) ld_req = 0;
      if (st_req && st_done) st_req = 0;
    end
    flush_in = 0;
    prev_rdy = rdy_in;
    if (!rst_in) begin
      mc_done = 0; ctl_active = 0;
    end else begin
      if (mc_done && prev_rdy) begin mc_done = 0; ctl_active = 0; end
      rdy_in = rdy_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
      if (rdy_in && !mc_done) begin
        if (ctl_active) begin
          if (ctl_wait == 0) begin
            mc_done = 1; done_raise_step = nstep;
            mc_rdata = fix_data_en ? fix_data : $urandom();
          end else begin
            ctl_wait--;
          end
        end else if (mc_read || mc_write) begin
          ctl_active = 1;
          ctl_wait = (ctl_delay >= 0) ? ctl_delay : int'($urandom_range(0, 4));
        end
      end
    end
    if (rand_en) begin
      if (!if_req && $urandom_range(0, 3) == 0) begin if_req = 1; if_addr = $urandom(); end
      else if (if_req && $urandom_range(0, 7) == 0) if_addr = $urandom();
      if (!ld_req && $urandom_range(0, 3) == 0) begin
        ld_req = 1; ld_addr = $urandom(); ld_len = rand_len();
      end
      if (!st_req && $urandom_range(0, 5) == 0) begin
        st_req = 1; st_addr = $urandom(); st_len = rand_len(); st_wdata = $urandom();
      end
      flush_in = ($urandom_range(0, 11) == 0);
    end
  endtask

  task automatic do_reset();
    rst_in = 0; if_req = 0; ld_req = 0; st_req = 0; flush_in = 0;
    keep_req = 0; rand_en = 0; rdy_rand = 0; fix_data_en = 0;
    step(); step();
    rst_in = 1;
  endtask

  initial begin
    logic [31:0] exp2 [3];
    logic [31:0] exp_a;
    int          ifd;
    bit          got, rd_at_done;

    do_reset();
    chk("rst_mc_read", 32'(mc_read), 32'd0);
    chk("rst_mc_write", 32'(mc_write), 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    chk("rst_dones", 32'({if_done, ld_done, st_done}), 32'd0);

    // Reset in the middle of a store.
    ctl_delay = 8;
    st_req = 1; st_addr = 32'h40; st_len = 3'd4; st_wdata = 32'h1234_5678;
    for (int i = 0; i < 20 && !mc_write; i++) step();
    chk("t1_write_up", 32'(mc_write), 32'd1);
    st_req = 0;
    step();
    @(posedge clk); #2 rst_in = 0; #1;
    chk("t1_write_drop", 32'(mc_write), 32'd0);
    chk("t1_no_done", 32'(st_done), 32'd0);
    step(); rst_in = 1; step(); step();
    chk("t1_idle", 32'(mc_write | mc_read), 32'd0);
    chk("t1_no_done2", 32'(st_done), 32'd0);

    // All three requests at once: store, then load, then fetch, each a separate strobe burst.
    do_reset(); ctl_delay = 1; gq.delete();
    st_req = 1; st_addr = 32'h300; st_len = 3'd4; st_wdata = 32'hCAFE_0001;
    ld_req = 1; ld_addr = 32'h200; ld_len = 3'd2;
    if_req = 1; if_addr = 32'h100;
    for (int i = 0; i < 100 && (st_req || ld_req || if_req); i++) step();
    step(); step();
    exp2 = '{32'h300, 32'h200, 32'h100};
    chk("t2_count", 32'(gq.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("t2_order", (i < gq.size()) ? gq[i] : 32'hFFFF_FFFF, exp2[i]);

    // Fetch flushed two cycles after grant: strobe held to completion, no if_done.
    do_reset(); ctl_delay = 6; gq.delete();
    if_req = 1; if_addr = 32'h1000;
    for (int i = 0; i < 20 && !mc_read; i++) step();
    chk("t3_grant_addr", mc_addr, 32'h1000);
    step(); flush_in = 1;
    ifd = 0; rd_at_done = 0;
    for (int i = 0; i < 40 && mc_read; i++) begin
      step();
      if (if_done) ifd++;
      if (mc_done) rd_at_done = mc_read;
    end
    step(); step();
    if (if_done) ifd++;
    chk("t3_read_held", 32'(rd_at_done), 32'd1);
    chk("t3_no_if_done", 32'(ifd), 32'd0);
    if_req = 1; if_addr = 32'h2000;
    for (int i = 0; i < 20 && !mc_read; i++) step();
    chk("t3_regrant_addr", mc_addr, 32'h2000);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin step(); if (if_done) got = 1; end
    chk("t3_if_done", 32'(got), 32'd1);

    // Byte load: upper bytes cleared, done one cycle after mc_done.
    do_reset(); ctl_delay = 2; fix_data_en = 1; fix_data = 32'hDEAD_BEEF;
    ld_req = 1; ld_addr = 32'h80; ld_len = 3'd1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin step(); if (ld_done) got = 1; end
    chk("t4_done", 32'(got), 32'd1);
    chk("t4_rdata", ld_rdata, 32'h0000_00EF);
    chk("t4_latency", 32'(nstep - done_raise_step), 32'd1);
    chk("t4_read_low", 32'(mc_read), 32'd0);

    // Flush during a store has no effect on it.
    do_reset(); ctl_delay = 4;
    st_req = 1; st_addr = 32'h0003_0000; st_len = 3'd1; st_wdata = 32'h41;
    for (int i = 0; i < 20 && !mc_write; i++) step();
    chk("t5_wdata", mc_wdata, 32'h41);
    chk("t5_addr", mc_addr, 32'h0003_0000);
    flush_in = 1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin step(); if (st_done) got = 1; end
    chk("t5_st_done", 32'(got), 32'd1);

    // Continuous store and fetch pressure: starvation guard decides whether fetch ever wins.
    do_reset(); ctl_delay = 0; gq.delete(); keep_req = 1;
    st_req = 1; st_addr = 32'h500; st_len = 3'd4; st_wdata = 32'h5;
    if_req = 1; if_addr = 32'h600;
    for (int i = 0; i < 300 && gq.size() < 10; i++) step();
    chk("t6_count", 32'(gq.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      exp_a = (GUARD && (i % 5 == 4)) ? 32'h600 : 32'h500;
      chk("t6_seq", (i < gq.size()) ? gq[i] : 32'hFFFF_FFFF, exp_a);
    end

    // Randomized traffic with freezes and flushes, checked every cycle against the model.
    do_reset(); ctl_delay = -1; rand_en = 1; rdy_rand = 1;
    repeat (4000) step();
    rand_en = 0; rdy_rand = 0;
    for (int i = 0; i < 400 && (if_req || ld_req || st_req || mc_read || mc_write); i++) step();
    step(); step();
    chk("drain_idle", 32'({if_req, ld_req, st_req, mc_read, mc_write}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
